bip_control: RTL and testbench

Sequencing control unit for the accumulator datapath. It fetches 16-bit instructions from synchronous program memory, decodes the opcode and drives every datapath select and write-enable, including `o_sel_B`, which steers the operand mux between data-RAM read data and the sign-extended immediate. It supports free-run and single-step modes for the debug unit and halts on `HLT`.

---
 rtl/bip_pkg.sv | 38 +++
 rtl/bip_control_if.sv | 32 +++
 rtl/bip_decoder.sv | 55 +++++
 rtl/bip_control.sv | 84 ++++++++
 tb/tb_bip_control.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/bip_pkg.sv
// Shared definitions for the accumulator sequencer: field widths, opcodes,
// FSM state encoding, accumulator-source codes and the decoded control bundle.
package bip_pkg;
   localparam int PC_BITS  = 11;
   localparam int OPC_BITS = 5;
   localparam int OPR_BITS = 11;
   localparam int CNT_BITS = 16;
   localparam int INS_BITS = OPC_BITS + OPR_BITS;

   localparam logic [OPC_BITS-1:0] OP_HLT  = 5'b00000;
   localparam logic [OPC_BITS-1:0] OP_STO  = 5'b00001;
   localparam logic [OPC_BITS-1:0] OP_LD   = 5'b00010;
   localparam logic [OPC_BITS-1:0] OP_LDI  = 5'b00011;
   localparam logic [OPC_BITS-1:0] OP_ADD  = 5'b00100;
   localparam logic [OPC_BITS-1:0] OP_ADDI = 5'b00101;
   localparam logic [OPC_BITS-1:0] OP_SUB  = 5'b00110;
   localparam logic [OPC_BITS-1:0] OP_SUBI = 5'b00111;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_EXEC  = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   localparam logic [1:0] SELA_MUX  = 2'd0;
   localparam logic [1:0] SELA_ALU  = 2'd1;
   localparam logic [1:0] SELA_HOLD = 2'd2;

   typedef struct packed {
      logic [1:0] sel_a;
      logic       sel_b;
      logic       op_sub;
      logic       wr_acc;
      logic       rd_ram;
      logic       wr_ram;
      logic       illegal;
      logic       halt;
   } ctrl_t;
endpackage

// File: rtl/bip_control_if.sv
// Debug requests, program-memory port and datapath controls of the sequencer.
// master = sequencer side, slave = debug unit / memory / datapath side.
interface bip_control_if;
   logic                         i_run;
   logic                         i_step;
   logic                         i_clear;
   logic [bip_pkg::PC_BITS-1:0]  o_pm_addr;
   logic                         o_pm_en;
   logic [bip_pkg::INS_BITS-1:0] i_pm_data;
   logic [bip_pkg::OPR_BITS-1:0] o_operand;
   logic [1:0]                   o_sel_A;
   logic                         o_sel_B;
   logic                         o_op_sub;
   logic                         o_wr_acc;
   logic                         o_rd_ram;
   logic                         o_wr_ram;
   logic                         o_halt;
   logic                         o_illegal;
   logic [bip_pkg::CNT_BITS-1:0] o_cycles;

   modport master (
      input  i_run, i_step, i_clear, i_pm_data,
      output o_pm_addr, o_pm_en, o_operand, o_sel_A, o_sel_B, o_op_sub,
             o_wr_acc, o_rd_ram, o_wr_ram, o_halt, o_illegal, o_cycles
   );

   modport slave (
      output i_run, i_step, i_clear, i_pm_data,
      input  o_pm_addr, o_pm_en, o_operand, o_sel_A, o_sel_B, o_op_sub,
             o_wr_acc, o_rd_ram, o_wr_ram, o_halt, o_illegal, o_cycles
   );
endinterface

// File: rtl/bip_decoder.sv
// Combinational opcode-to-control mapping; zero latency, no backpressure.
// With en low every strobe is 0, sel_a holds and the operand reads 0.
module bip_decoder
   import bip_pkg::*;
(
   input  logic                en,
   input  logic [INS_BITS-1:0] instr,
   output ctrl_t               ctrl,
   output logic [OPR_BITS-1:0] operand
);
   logic [OPC_BITS-1:0] opc;
   assign opc = instr[INS_BITS-1 -: OPC_BITS];

   always_comb begin
      ctrl.sel_a   = SELA_HOLD;
      ctrl.sel_b   = 1'b0;
      ctrl.op_sub  = 1'b0;
      ctrl.wr_acc  = 1'b0;
      ctrl.rd_ram  = 1'b0;
      ctrl.wr_ram  = 1'b0;
      ctrl.illegal = 1'b0;
      ctrl.halt    = 1'b0;
      operand      = '0;
      if (en) begin
         operand = instr[OPR_BITS-1:0];
         case (opc)
            OP_HLT: ctrl.halt = 1'b1;
            OP_STO: ctrl.wr_ram = 1'b1;
            OP_LD: begin
               ctrl.rd_ram = 1'b1;
               ctrl.sel_a  = SELA_MUX;
               ctrl.wr_acc = 1'b1;
            end
            OP_LDI: begin
               ctrl.sel_b  = 1'b1;
               ctrl.sel_a  = SELA_MUX;
               ctrl.wr_acc = 1'b1;
            end
            OP_ADD, OP_SUB: begin
               ctrl.rd_ram = 1'b1;
               ctrl.sel_a  = SELA_ALU;
               ctrl.wr_acc = 1'b1;
               ctrl.op_sub = (opc == OP_SUB);
            end
            OP_ADDI, OP_SUBI: begin
               ctrl.sel_b  = 1'b1;
               ctrl.sel_a  = SELA_ALU;
               ctrl.wr_acc = 1'b1;
               ctrl.op_sub = (opc == OP_SUBI);
            end
            default: ctrl.illegal = 1'b1;
         endcase
      end
   end
endmodule

// File: rtl/bip_control.sv
// Fetch/execute sequencer: 2 cycles per instruction (FETCH, EXEC), free-run or single-step.
// No backpressure: memory data is expected one cycle after o_pm_en; i_clear overrides run/step.
module bip_control
   import bip_pkg::*;
(
   input  logic           i_clk,
   input  logic           i_rst_n,
   bip_control_if.master  bus
);
   logic [1:0]          state;
   logic [1:0]          state_nxt;
   logic [PC_BITS-1:0]  pc;
   logic                step_mode;
   logic                halt_q;
   logic [CNT_BITS-1:0] cycles;
   logic                exec;
   logic                go;
   ctrl_t               ctrl;
   logic [OPR_BITS-1:0] operand;

   assign exec = (state == ST_EXEC);
   assign go   = bus.i_run | bus.i_step;

   bip_decoder u_dec (
      .en      (exec),
      .instr   (bus.i_pm_data),
      .ctrl    (ctrl),
      .operand (operand)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (go) state_nxt = ST_FETCH;
         ST_FETCH: state_nxt = ST_EXEC;
         ST_EXEC: begin
            if (ctrl.halt)                     state_nxt = ST_HALT;
            else if (!step_mode && bus.i_run)  state_nxt = ST_FETCH;
            else                               state_nxt = ST_IDLE;
         end
         ST_HALT:  state_nxt = ST_HALT;
         default:  state_nxt = ST_IDLE;
      endcase
      if (bus.i_clear) state_nxt = ST_IDLE;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_IDLE;
         pc        <= '0;
         step_mode <= 1'b0;
         halt_q    <= 1'b0;
         cycles    <= '0;
      end else begin
         state  <= state_nxt;
         halt_q <= (state_nxt == ST_HALT);
         if (bus.i_clear) begin
            pc     <= '0;
            cycles <= '0;
         end else begin
            // run beats step when both arrive together
            if (state == ST_IDLE && go)
               step_mode <= ~bus.i_run;
            if (exec && !ctrl.halt)
               pc <= pc + 1'b1;
            if ((state == ST_FETCH || exec) && cycles != {CNT_BITS{1'b1}})
               cycles <= cycles + 1'b1;
         end
      end
   end

   assign bus.o_pm_addr = pc;
   assign bus.o_pm_en   = (state == ST_FETCH);
   assign bus.o_operand = operand;
   assign bus.o_sel_A   = ctrl.sel_a;
   assign bus.o_sel_B   = ctrl.sel_b;
   assign bus.o_op_sub  = ctrl.op_sub;
   assign bus.o_wr_acc  = ctrl.wr_acc;
   assign bus.o_rd_ram  = ctrl.rd_ram;
   assign bus.o_wr_ram  = ctrl.wr_ram;
   assign bus.o_halt    = halt_q;
   assign bus.o_illegal = ctrl.illegal;
   assign bus.o_cycles  = cycles;
endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control: reset, free run to HLT, clear, single step,
// illegal opcode, PC wrap and asynchronous reset in EXEC.
module tb_bip_control;
   import bip_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic found;
   logic [15:0] mem [0:2047];

   logic       st_rd   [3] = '{1'b1, 1'b1, 1'b0};
   logic       st_sub  [3] = '{1'b0, 1'b1, 1'b1};
   logic       st_selb [3] = '{1'b0, 1'b0, 1'b1};
   logic [1:0] st_sela [3] = '{2'd0, 2'd1, 2'd1};

   bip_control_if bus ();

   bip_control dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // synchronous program memory: data one cycle after the enable
   always @(posedge clk)
      if (bus.o_pm_en) bus.i_pm_data <= mem[bus.o_pm_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // order: pm_en wr_acc rd_ram wr_ram illegal op_sub sel_B sel_A[1:0]
   task automatic chk_ctl(input string tag, input logic pm_en, input logic wr_acc,
                          input logic rd_ram, input logic wr_ram, input logic illegal,
                          input logic op_sub, input logic sel_b, input logic [1:0] sel_a);
      chk(tag, {23'd0, bus.o_pm_en, bus.o_wr_acc, bus.o_rd_ram, bus.o_wr_ram,
                bus.o_illegal, bus.o_op_sub, bus.o_sel_B, bus.o_sel_A},
               {23'd0, pm_en, wr_acc, rd_ram, wr_ram, illegal, op_sub, sel_b, sel_a});
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      bus.i_run   = 1'b0;
      bus.i_step  = 1'b0;
      bus.i_clear = 1'b0;
      found       = 1'b0;
      for (int i = 0; i < 2048; i++) mem[i] = 16'h4000;   // opcode 01000: undefined, acts as NOP
      mem[0] = 16'h1805;   // LDI 5
      mem[1] = 16'h2803;   // ADDI 3
      mem[2] = 16'h0802;   // STO 2
      mem[3] = 16'h0000;   // HLT
      mem[4] = 16'hF800;   // opcode 11111

      // reset
      cyc(); cyc();
      chk_ctl("rst_ctl", 0, 0, 0, 0, 0, 0, 0, 2'd2);
      chk("rst_addr", bus.o_pm_addr, 0);
      chk("rst_halt", bus.o_halt, 0);
      chk("rst_cycles", bus.o_cycles, 0);
      rst_n = 1'b1;

      // free run: LDI 5; ADDI 3; STO 2; HLT
      bus.i_run = 1'b1;
      cyc();
      chk_ctl("fr_c1_fetch", 1, 0, 0, 0, 0, 0, 0, 2'd2);
      chk("fr_c1_addr", bus.o_pm_addr, 0);
      cyc();
      chk_ctl("fr_c2_ldi", 0, 1, 0, 0, 0, 0, 1, 2'd0);
      chk("fr_c2_operand", bus.o_operand, 5);
      cyc();
      chk("fr_c3_addr", bus.o_pm_addr, 1);
      cyc();
      chk_ctl("fr_c4_addi", 0, 1, 0, 0, 0, 0, 1, 2'd1);
      cyc();
      chk_ctl("fr_c5_fetch", 1, 0, 0, 0, 0, 0, 0, 2'd2);
      cyc();
      chk_ctl("fr_c6_sto", 0, 0, 0, 1, 0, 0, 0, 2'd2);
      chk("fr_c6_operand", bus.o_operand, 2);
      cyc();
      chk("fr_c7_addr", bus.o_pm_addr, 3);
      cyc();
      chk_ctl("fr_c8_hlt", 0, 0, 0, 0, 0, 0, 0, 2'd2);
      chk("fr_c8_halt_low", bus.o_halt, 0);
      cyc();
      chk("fr_halt", bus.o_halt, 1);
      chk("fr_pc", bus.o_pm_addr, 3);
      chk("fr_cycles", bus.o_cycles, 8);
      cyc();
      chk("halt_hold", bus.o_halt, 1);
      chk("halt_no_fetch", bus.o_pm_en, 0);
      chk("halt_cycles", bus.o_cycles, 8);

      // clear together with run while halted, then run from address 0
      bus.i_clear = 1'b1;
      cyc();
      bus.i_clear = 1'b0;
      chk("clr_halt", bus.o_halt, 0);
      chk("clr_pc", bus.o_pm_addr, 0);
      chk("clr_cycles", bus.o_cycles, 0);
      chk("clr_idle", bus.o_pm_en, 0);
      cyc();
      chk("rerun_fetch", bus.o_pm_en, 1);
      chk("rerun_addr", bus.o_pm_addr, 0);
      bus.i_run = 1'b0;   // dropped during FETCH: in-flight LDI still executes
      cyc();
      chk_ctl("rerun_exec", 0, 1, 0, 0, 0, 0, 1, 2'd0);
      cyc();
      chk_ctl("rerun_idle", 0, 0, 0, 0, 0, 0, 0, 2'd2);
      chk("rerun_pc", bus.o_pm_addr, 1);
      chk("rerun_cycles", bus.o_cycles, 2);

      // single step: LD 7; SUB 7; SUBI 1
      mem[1] = 16'h1007;
      mem[2] = 16'h3007;
      mem[3] = 16'h3801;
      for (int k = 0; k < 3; k++) begin
         bus.i_step = 1'b1;
         cyc();
         bus.i_step = 1'b0;
         chk($sformatf("step%0d_fetch", k), bus.o_pm_en, 1);
         chk($sformatf("step%0d_addr", k), bus.o_pm_addr, 1 + k);
         cyc();
         chk_ctl($sformatf("step%0d_exec", k), 0, 1, st_rd[k], 0, 0, st_sub[k], st_selb[k], st_sela[k]);
         chk($sformatf("step%0d_operand", k), bus.o_operand, (k == 2) ? 1 : 7);
         cyc();
         chk_ctl($sformatf("step%0d_idle", k), 0, 0, 0, 0, 0, 0, 0, 2'd2);
      end
      cyc();
      chk("step_stays_idle", bus.o_pm_en, 0);
      chk("step_cycles", bus.o_cycles, 8);

      // illegal opcode 11111 at address 4
      bus.i_step = 1'b1;
      cyc();
      bus.i_step = 1'b0;
      chk("ill_addr", bus.o_pm_addr, 4);
      cyc();
      chk_ctl("ill_exec", 0, 0, 0, 0, 1, 0, 0, 2'd2);
      cyc();
      chk("ill_pulse_end", bus.o_illegal, 0);
      chk("ill_pc", bus.o_pm_addr, 5);
      chk("ill_cycles", bus.o_cycles, 10);

      // free run through NOPs up to PC 2047, stop there and check the wrap
      bus.i_run = 1'b1;
      for (int n = 0; n < 5000; n++) begin
         cyc();
         if (bus.o_pm_en === 1'b1 && bus.o_pm_addr === 11'h7FF) begin
            found = 1'b1;
            break;
         end
      end
      bus.i_run = 1'b0;
      chk("wrap_reached", found, 1);
      cyc();
      chk_ctl("wrap_exec", 0, 0, 0, 0, 1, 0, 0, 2'd2);
      cyc();
      chk("wrap_pc", bus.o_pm_addr, 0);
      chk("wrap_cycles", bus.o_cycles, 4096);

      // asynchronous reset in the middle of EXEC
      bus.i_run = 1'b1;
      cyc();
      chk("ar_fetch_addr", bus.o_pm_addr, 0);
      cyc();
      chk("ar_exec_wr_acc", bus.o_wr_acc, 1);
      bus.i_run = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk_ctl("ar_ctl", 0, 0, 0, 0, 0, 0, 0, 2'd2);
      chk("ar_pc", bus.o_pm_addr, 0);
      chk("ar_cycles", bus.o_cycles, 0);
      cyc();
      rst_n = 1'b1;
      cyc();
      chk_ctl("ar_after", 0, 0, 0, 0, 0, 0, 0, 2'd2);
      chk("ar_after_pc", bus.o_pm_addr, 0);
      chk("ar_after_halt", bus.o_halt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
